// File: rtl/sram_audio_transport_if.sv
// SRAM controller port used by the audio transport: active-low strobes, word address and data.
interface sram_audio_transport_if #(
  parameter int SW = 16,
  parameter int AW = 20
);
  logic          chipselect_n;
  logic          write_n;
  logic          read_n;
  logic [AW-1:0] address;
  logic [SW-1:0] writedata;
  logic [SW-1:0] readdata;

  modport master (output chipselect_n, write_n, read_n, address, writedata, input readdata);
  modport slave  (input chipselect_n, write_n, read_n, address, writedata, output readdata);
endinterface

// File: rtl/sram_audio_transport.sv
// N-channel SRAM record/playback engine with Q4.4 speed, reverse play and pass-through monitoring.
// Optional feature macro AUDIO_LOOP_EN: looped playback and wrap-around recording.
module sram_audio_transport #(
  parameter int SW  = 16,
  parameter int NCH = 2,
  parameter int AW  = 20
) (
  input  logic                      CLOCK_50,
  input  logic                      RST,
  input  logic                      cmd_rec,
  input  logic                      cmd_play,
  input  logic                      cmd_thru,
  input  logic                      cmd_stop,
  input  logic [7:0]                speed,
  input  logic                      reverse,
  input  logic                      frame_stb,
  input  logic [NCH*SW-1:0]         sample_in,
  output logic [NCH*SW-1:0]         sample_out,
  output logic                      out_valid,
  sram_audio_transport_if.master    sram,
  output logic [2:0]                state_o,
  output logic                      overrun,
  output logic [AW-$clog2(NCH)-1:0] rec_len
);
  localparam int LNCH = $clog2(NCH);
  localparam int FW   = AW - LNCH;
  localparam int CW   = (LNCH > 0) ? LNCH : 1;
  localparam int PW   = FW + 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_THRU = 3'd1,
    S_REC  = 3'd2,
    S_PLAY = 3'd3
  } state_t;

  state_t            state_q, state_d, cmd_state_s;
  logic              cmd_take_s, stop_now_s, end_s;
  logic              from_thru_q, from_thru_d, busy_q, busy_d, stop_pend_q, stop_pend_d;
  logic              overrun_q, overrun_d, out_valid_q, out_valid_d, rev_q, rev_d;
  logic              cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [3:0]        cyc_q, cyc_d;
  logic [FW-1:0]     wcnt_q, wcnt_d, rec_len_q, rec_len_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [PW:0]       fwd_s, rev_s;
  logic [7:0]        spd_q, spd_d;
  logic [NCH*SW-1:0] frame_q, frame_d, rbuf_q, rbuf_d, sout_q, sout_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [SW-1:0]     wdata_q, wdata_d;

  function automatic logic [AW-1:0] addr_f(input logic [FW-1:0] frm, input logic [CW-1:0] ch);
    return (AW'(frm) << LNCH) | AW'(ch);
  endfunction

  assign stop_now_s = stop_pend_q | cmd_stop;
  assign fwd_s      = {1'b0, pos_q} + (PW+1)'(spd_q);
  assign rev_s      = {1'b0, pos_q} - (PW+1)'(spd_q);
  // Reverse ends on a borrow below frame 0, forward once the integer part passes the recording
  assign end_s      = rev_q ? rev_s[PW] : (fwd_s[PW:4] >= {1'b0, rec_len_q});

  // Command acceptance per state, priority stop > rec > play > thru
  always_comb begin
    cmd_state_s = state_q;
    cmd_take_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_stop) begin
          cmd_take_s = 1'b0;
        end else if (cmd_rec) begin
          cmd_state_s = S_REC;
          cmd_take_s  = 1'b1;
        end else if (cmd_play && (rec_len_q != '0)) begin
          cmd_state_s = S_PLAY;
          cmd_take_s  = 1'b1;
        end else if (cmd_thru) begin
          cmd_state_s = S_THRU;
          cmd_take_s  = 1'b1;
        end else begin
          cmd_take_s = 1'b0;
        end
      end
      S_THRU: begin
        if (cmd_stop) begin
          cmd_state_s = S_IDLE;
          cmd_take_s  = 1'b1;
        end else if (cmd_rec) begin
          cmd_state_s = S_REC;
          cmd_take_s  = 1'b1;
        end else begin
          cmd_take_s = 1'b0;
        end
      end
      S_REC, S_PLAY: begin
        if (cmd_stop && !busy_q) begin
          cmd_state_s = S_IDLE;
          cmd_take_s  = 1'b1;
        end else begin
          cmd_take_s = 1'b0;
        end
      end
      default: begin
        cmd_state_s = S_IDLE;
        cmd_take_s  = 1'b1;
      end
    endcase
  end

  // Next state: monitoring, per-frame SRAM write/read sequencing and playback position
  always_comb begin
    int k;
    k           = int'(cyc_q);
    state_d     = state_q;
    from_thru_d = from_thru_q;
    busy_d      = busy_q;
    cyc_d       = cyc_q;
    stop_pend_d = stop_pend_q;
    overrun_d   = overrun_q;
    wcnt_d      = wcnt_q;
    rec_len_d   = rec_len_q;
    pos_d       = pos_q;
    spd_d       = spd_q;
    rev_d       = rev_q;
    frame_d     = frame_q;
    rbuf_d      = rbuf_q;
    sout_d      = sout_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_valid_d = 1'b0;
    cs_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    rd_n_d      = 1'b1;
    if (cmd_take_s) begin
      state_d     = cmd_state_s;
      busy_d      = 1'b0;
      stop_pend_d = 1'b0;
      case (cmd_state_s)
        S_REC: begin
          wcnt_d      = '0;
          rec_len_d   = '0;
          overrun_d   = 1'b0;
          from_thru_d = (state_q == S_THRU);
        end
        S_PLAY: begin
          overrun_d = 1'b0;
          spd_d     = (speed == 8'h00) ? 8'h10 : speed;
          rev_d     = reverse;
          pos_d     = reverse ? {rec_len_q - FW'(1), 4'h0} : '0;
        end
        default: from_thru_d = 1'b0;
      endcase
    end else if (busy_q) begin
      overrun_d   = overrun_q | frame_stb;
      stop_pend_d = stop_pend_q | cmd_stop;
      cyc_d       = cyc_q + 4'd1;
      if (state_q == S_REC) begin
        if (k < NCH) begin
          cs_n_d  = 1'b0;
          wr_n_d  = 1'b0;
          addr_d  = addr_f(wcnt_q, CW'(cyc_q));
          wdata_d = frame_q[k*SW +: SW];
        end else begin
          busy_d      = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = stop_now_s ? S_IDLE : S_REC;
          if (wcnt_q == '1) begin
`ifdef AUDIO_LOOP_EN
            wcnt_d = '0;
`else
            state_d = (!stop_now_s && from_thru_q) ? S_THRU : S_IDLE;
`endif
            // rec_len is FW bits wide, so a full memory reads back as all-ones
            rec_len_d = '1;
          end else begin
            wcnt_d = wcnt_q + FW'(1);
`ifdef AUDIO_LOOP_EN
            rec_len_d = (rec_len_q == '1) ? '1 : (wcnt_q + FW'(1));
`else
            rec_len_d = wcnt_q + FW'(1);
`endif
          end
        end
      end else begin
        if (k < NCH) begin
          cs_n_d = 1'b0;
          rd_n_d = 1'b0;
          addr_d = addr_f(pos_q[PW-1:4], CW'(cyc_q));
        end else begin
          rd_n_d = 1'b1;
        end
        if (k >= 2) begin
          rbuf_d[(k-2)*SW +: SW] = sram.readdata;
        end else begin
          rbuf_d = rbuf_q;
        end
        if (k == NCH + 1) begin
          sout_d      = rbuf_d;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          stop_pend_d = 1'b0;
          if (end_s) begin
`ifdef AUDIO_LOOP_EN
            pos_d   = rev_q ? {rec_len_q - FW'(1), 4'h0} : '0;
            state_d = stop_now_s ? S_IDLE : S_PLAY;
`else
            state_d = S_IDLE;
`endif
          end else begin
            pos_d   = rev_q ? rev_s[PW-1:0] : fwd_s[PW-1:0];
            state_d = stop_now_s ? S_IDLE : S_PLAY;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
    end else if (frame_stb) begin
      case (state_q)
        S_THRU: begin
          sout_d      = sample_in;
          out_valid_d = 1'b1;
        end
        S_REC: begin
          sout_d      = sample_in;
          out_valid_d = 1'b1;
          frame_d     = sample_in;
          busy_d      = 1'b1;
          cyc_d       = 4'd1;
          cs_n_d      = 1'b0;
          wr_n_d      = 1'b0;
          addr_d      = addr_f(wcnt_q, '0);
          wdata_d     = sample_in[SW-1:0];
        end
        S_PLAY: begin
          busy_d = 1'b1;
          cyc_d  = 4'd1;
          cs_n_d = 1'b0;
          rd_n_d = 1'b0;
          addr_d = addr_f(pos_q[PW-1:4], '0);
        end
        default: out_valid_d = 1'b0;
      endcase
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously by RST
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      from_thru_q <= 1'b0;
      busy_q      <= 1'b0;
      cyc_q       <= 4'd0;
      stop_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      wcnt_q      <= '0;
      rec_len_q   <= '0;
      pos_q       <= '0;
      spd_q       <= 8'h10;
      rev_q       <= 1'b0;
      frame_q     <= '0;
      rbuf_q      <= '0;
      sout_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      from_thru_q <= from_thru_d;
      busy_q      <= busy_d;
      cyc_q       <= cyc_d;
      stop_pend_q <= stop_pend_d;
      overrun_q   <= overrun_d;
      wcnt_q      <= wcnt_d;
      rec_len_q   <= rec_len_d;
      pos_q       <= pos_d;
      spd_q       <= spd_d;
      rev_q       <= rev_d;
      frame_q     <= frame_d;
      rbuf_q      <= rbuf_d;
      sout_q      <= sout_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_valid_q <= out_valid_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
    end
  end

  assign sample_out        = sout_q;
  assign out_valid         = out_valid_q;
  assign sram.chipselect_n = cs_n_q;
  assign sram.write_n      = wr_n_q;
  assign sram.read_n       = rd_n_q;
  assign sram.address      = addr_q;
  assign sram.writedata    = wdata_q;
  assign state_o           = state_q;
  assign overrun           = overrun_q;
  assign rec_len           = rec_len_q;

endmodule
